// File: rtl/enkel_pkg.sv
// Shared opcodes, FSM state codes and the control-word layout for the enkel sequencer.
package enkel_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_JMP   = 3'b011;
    localparam logic [2:0] OP_LDI   = 3'b100;
    localparam logic [2:0] OP_SHOW  = 3'b101;
    localparam logic [2:0] OP_ALU   = 3'b110;
    localparam logic [2:0] OP_BRZ   = 3'b111;

    typedef enum logic [3:0] {
        StReset    = 4'd0,
        StIdle     = 4'd1,
        StFAddr    = 4'd2,
        StFRead    = 4'd3,
        StFInc     = 4'd4,
        StDecode   = 4'd5,
        StE1       = 4'd6,
        StE2       = 4'd7,
        StHalt     = 4'd8,
        StProgAddr = 4'd9,
        StProgWait = 4'd10,
        StProgWr   = 4'd11,
        StProgInc  = 4'd12
    } state_e;

    typedef struct packed {
        logic mar_load;
        logic pc_load;
        logic ir_load;
        logic latch_pc_load;
        logic show_load;
        logic pc_reset;
        logic ir_reset;
        logic mar_reset;
        logic show_reset;
        logic ir_pc_select;
        logic inc_alu_select;
        logic en_inc;
        logic a_programmer_select;
        logic apc;
        logic bc;
        logic mem_we;
        logic a_load;
        logic b_load;
        logic b_src_ir;
        logic alu_en;
        logic halted;
        logic prog_ready;
    } ctrl_t;

    // Quiescent word: every strobe low, A register selected onto the memory bus.
    function automatic ctrl_t ctrl_default();
        ctrl_t c;
        c = '0;
        c.a_programmer_select = 1'b1;
        return c;
    endfunction

    // Opcodes whose first execute cycle points MAR at the IR operand.
    function automatic logic is_mem_op(logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_SHOW);
    endfunction

endpackage

// File: rtl/enkel_mem_wait_counter.sv
// Down-counter that stretches RAM accesses; done_next_o tells whether the cycle being
// entered is the final one of the stretch.
module enkel_mem_wait_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o,
    output logic             done_next_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o      = (cnt_q == '0);
    assign done_next_o = (cnt_d == '0);

endmodule

// File: rtl/enkel_control_unit.sv
// Microsequencer for the enkel datapath: fetch/decode/execute/halt plus a programming
// mode. All strobes are registered from the next state so they line up with state_dbg.
module enkel_control_unit
    import enkel_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CNT_W    = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic       prog_mode,
    input  logic       prog_valid,
    output logic       prog_ready,
    input  logic [2:0] opcode,
    input  logic       status,
    input  logic       zero_flag,
    output logic       mar_load,
    output logic       pc_load,
    output logic       ir_load,
    output logic       latch_pc_load,
    output logic       show_load,
    output logic       pc_reset,
    output logic       ir_reset,
    output logic       mar_reset,
    output logic       show_reset,
    output logic       ir_pc_select,
    output logic       inc_alu_select,
    output logic       en_inc,
    output logic       a_programmer_select,
    output logic       apc,
    output logic       bc,
    output logic       mem_we,
    output logic       a_load,
    output logic       b_load,
    output logic       b_src_ir,
    output logic       alu_en,
    output logic       halted,
    output logic [3:0] state_dbg
);

    state_e     state_q, state_d, ret_state;
    logic [2:0] op_q, op_d;
    logic       boot_q;
    logic       tail_q, tail_d;
    logic       ready_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       cnt_load, cnt_dec, cnt_done, cnt_done_next;

    enkel_mem_wait_counter #(
        .CNT_W(CNT_W)
    ) u_wait (
        .clk_i      (clk),
        .rst_ni     (reset_n),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MEM_WAIT)),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done),
        .done_next_o(cnt_done_next)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tail_d    = 1'b0;
        ready_d   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        ret_state = run ? StFAddr : StIdle;
        ctrl_d    = ctrl_default();

        case (state_q)
            // First cycle after reset release holds RESET so the clears are issued once.
            StReset:    state_d = boot_q ? StIdle : StReset;
            StIdle: begin
                if (prog_mode) begin
                    state_d = StProgAddr;
                end else if (run) begin
                    state_d = StFAddr;
                end
            end
            StFAddr: begin
                state_d  = StFRead;
                cnt_load = 1'b1;
            end
            StFRead: begin
                if (cnt_done) begin
                    state_d = StFInc;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StFInc:     state_d = StDecode;
            StDecode: begin
                if (!status) begin
                    state_d = StHalt;
                end else begin
                    state_d = StE1;
                    op_d    = opcode;
                    // BRZ is resolved here into a JMP or a NOP.
                    if (opcode == OP_BRZ) begin
                        op_d = zero_flag ? OP_JMP : OP_NOP;
                    end
                end
            end
            StE1: begin
                if (is_mem_op(op_q) || (op_q == OP_JMP)) begin
                    state_d  = StE2;
                    cnt_load = 1'b1;
                end else begin
                    state_d = ret_state;
                end
            end
            StE2: begin
                if ((op_q == OP_JMP) || ((op_q == OP_STORE) && tail_q)) begin
                    state_d = ret_state;
                end else if (!cnt_done) begin
                    cnt_dec = 1'b1;
                end else if (op_q == OP_STORE) begin
                    tail_d = 1'b1;
                end else begin
                    state_d = ret_state;
                end
            end
            StHalt:     state_d = StHalt;
            StProgAddr: state_d = prog_mode ? StProgWait : StReset;
            StProgWait: begin
                if (ctrl_q.prog_ready) begin
                    state_d  = StProgWr;
                    cnt_load = 1'b1;
                end else begin
                    ready_d = prog_valid;
                end
            end
            StProgWr: begin
                if (cnt_done) begin
                    state_d = StProgInc;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StProgInc:  state_d = StProgAddr;
            default:    state_d = StReset;
        endcase

        case (state_d)
            StReset: begin
                ctrl_d.pc_reset   = 1'b1;
                ctrl_d.ir_reset   = 1'b1;
                ctrl_d.mar_reset  = 1'b1;
                ctrl_d.show_reset = 1'b1;
            end
            StFAddr, StProgAddr: ctrl_d.mar_load = 1'b1;
            StFRead: begin
                ctrl_d.bc      = 1'b1;
                ctrl_d.ir_load = cnt_done_next;
            end
            StFInc, StProgInc: begin
                ctrl_d.en_inc         = 1'b1;
                ctrl_d.inc_alu_select = 1'b1;
                ctrl_d.pc_load        = 1'b1;
            end
            StE1: begin
                case (op_d)
                    OP_LOAD, OP_STORE, OP_SHOW: begin
                        ctrl_d.ir_pc_select = 1'b1;
                        ctrl_d.mar_load     = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_d.alu_en        = 1'b1;
                        ctrl_d.latch_pc_load = 1'b1;
                    end
                    OP_LDI: begin
                        ctrl_d.b_src_ir = 1'b1;
                        ctrl_d.b_load   = 1'b1;
                    end
                    OP_ALU: begin
                        ctrl_d.alu_en = 1'b1;
                        ctrl_d.a_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            StE2: begin
                case (op_d)
                    OP_LOAD: begin
                        ctrl_d.bc     = 1'b1;
                        ctrl_d.b_load = cnt_done_next;
                    end
                    // Write drops one cycle ahead of the bus driver for hold time.
                    OP_STORE: begin
                        ctrl_d.apc    = 1'b1;
                        ctrl_d.mem_we = !tail_d;
                    end
                    OP_SHOW: begin
                        ctrl_d.bc        = 1'b1;
                        ctrl_d.show_load = cnt_done_next;
                    end
                    OP_JMP:  ctrl_d.pc_load = 1'b1;
                    default: ;
                endcase
            end
            StHalt:     ctrl_d.halted = 1'b1;
            StProgWait: begin
                ctrl_d.a_programmer_select = 1'b0;
                ctrl_d.apc                 = 1'b1;
                ctrl_d.prog_ready          = ready_d;
            end
            StProgWr: begin
                ctrl_d.a_programmer_select = 1'b0;
                ctrl_d.apc                 = 1'b1;
                ctrl_d.mem_we              = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StReset;
            op_q    <= OP_NOP;
            boot_q  <= 1'b0;
            tail_q  <= 1'b0;
            ctrl_q  <= ctrl_default();
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            boot_q  <= 1'b1;
            tail_q  <= tail_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign mar_load            = ctrl_q.mar_load;
    assign pc_load             = ctrl_q.pc_load;
    assign ir_load             = ctrl_q.ir_load;
    assign latch_pc_load       = ctrl_q.latch_pc_load;
    assign show_load           = ctrl_q.show_load;
    assign pc_reset            = ctrl_q.pc_reset;
    assign ir_reset            = ctrl_q.ir_reset;
    assign mar_reset           = ctrl_q.mar_reset;
    assign show_reset          = ctrl_q.show_reset;
    assign ir_pc_select        = ctrl_q.ir_pc_select;
    assign inc_alu_select      = ctrl_q.inc_alu_select;
    assign en_inc              = ctrl_q.en_inc;
    assign a_programmer_select = ctrl_q.a_programmer_select;
    assign apc                 = ctrl_q.apc;
    assign bc                  = ctrl_q.bc;
    assign mem_we              = ctrl_q.mem_we;
    assign a_load              = ctrl_q.a_load;
    assign b_load              = ctrl_q.b_load;
    assign b_src_ir            = ctrl_q.b_src_ir;
    assign alu_en              = ctrl_q.alu_en;
    assign halted              = ctrl_q.halted;
    assign prog_ready          = ctrl_q.prog_ready;
    assign state_dbg           = state_q;

endmodule

// File: tb/tb_enkel_control_unit.sv
// Bench: per-instruction cycle scripts build an expected strobe trace (with the inputs to
// drive each cycle) that is replayed against the sequencer.
module tb_enkel_control_unit;

    localparam int W = 1;

    localparam logic [3:0] S_RESET = 4'd0,  S_IDLE   = 4'd1,  S_FADDR = 4'd2,  S_FREAD = 4'd3;
    localparam logic [3:0] S_FINC  = 4'd4,  S_DECODE = 4'd5,  S_E1    = 4'd6,  S_E2    = 4'd7;
    localparam logic [3:0] S_HALT  = 4'd8,  S_PADDR  = 4'd9,  S_PWAIT = 4'd10, S_PWR   = 4'd11;
    localparam logic [3:0] S_PINC  = 4'd12;

    localparam logic [21:0] C_MAR  = 22'(1) << 21, C_PCL  = 22'(1) << 20, C_IRL  = 22'(1) << 19;
    localparam logic [21:0] C_LPC  = 22'(1) << 18, C_SHOW = 22'(1) << 17, C_PCR  = 22'(1) << 16;
    localparam logic [21:0] C_IRR  = 22'(1) << 15, C_MARR = 22'(1) << 14, C_SHR  = 22'(1) << 13;
    localparam logic [21:0] C_IPS  = 22'(1) << 12, C_INCS = 22'(1) << 11, C_INC  = 22'(1) << 10;
    localparam logic [21:0] C_APS  = 22'(1) << 9,  C_APC  = 22'(1) << 8,  C_BC   = 22'(1) << 7;
    localparam logic [21:0] C_WE   = 22'(1) << 6,  C_AL   = 22'(1) << 5,  C_BL   = 22'(1) << 4;
    localparam logic [21:0] C_BSRC = 22'(1) << 3,  C_ALU  = 22'(1) << 2,  C_HLT  = 22'(1) << 1;
    localparam logic [21:0] C_RDY  = 22'(1) << 0;
    localparam logic [21:0] C_CLRS = C_PCR | C_IRR | C_MARR | C_SHR;
    localparam logic [21:0] C_STEP = C_INC | C_INCS | C_PCL;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       run = 1'b0, prog_mode = 1'b0, prog_valid = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       status = 1'b1, zero_flag = 1'b0;
    logic       prog_ready, mar_load, pc_load, ir_load, latch_pc_load, show_load;
    logic       pc_reset, ir_reset, mar_reset, show_reset, ir_pc_select, inc_alu_select;
    logic       en_inc, a_programmer_select, apc, bc, mem_we, a_load, b_load, b_src_ir;
    logic       alu_en, halted;
    logic [3:0] state_dbg;

    enkel_control_unit #(
        .MEM_WAIT(W),
        .CNT_W   (2)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .run                (run),
        .prog_mode          (prog_mode),
        .prog_valid         (prog_valid),
        .prog_ready         (prog_ready),
        .opcode             (opcode),
        .status             (status),
        .zero_flag          (zero_flag),
        .mar_load           (mar_load),
        .pc_load            (pc_load),
        .ir_load            (ir_load),
        .latch_pc_load      (latch_pc_load),
        .show_load          (show_load),
        .pc_reset           (pc_reset),
        .ir_reset           (ir_reset),
        .mar_reset          (mar_reset),
        .show_reset         (show_reset),
        .ir_pc_select       (ir_pc_select),
        .inc_alu_select     (inc_alu_select),
        .en_inc             (en_inc),
        .a_programmer_select(a_programmer_select),
        .apc                (apc),
        .bc                 (bc),
        .mem_we             (mem_we),
        .a_load             (a_load),
        .b_load             (b_load),
        .b_src_ir           (b_src_ir),
        .alu_en             (alu_en),
        .halted             (halted),
        .state_dbg          (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        run, pm, pv, status, zf;
        logic [2:0]  op;
        logic [3:0]  state;
        logic [21:0] ctl;
    } cyc_t;

    cyc_t       exp_q[$];
    logic       in_run = 1'b0, in_pm = 1'b0, in_pv = 1'b0, in_status = 1'b1, in_zf = 1'b0;
    logic [2:0] in_op = 3'd0;
    logic       prev_ready = 1'b0;
    int         tests = 0, fails = 0;

    function automatic logic [21:0] observed();
        return {mar_load, pc_load, ir_load, latch_pc_load, show_load, pc_reset, ir_reset,
                mar_reset, show_reset, ir_pc_select, inc_alu_select, en_inc,
                a_programmer_select, apc, bc, mem_we, a_load, b_load, b_src_ir, alu_en,
                halted, prog_ready};
    endfunction

    task automatic check(input string tag, input logic [25:0] got, input logic [25:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, got, want);
        end
    endtask

    task automatic push(input logic [3:0] s, input logic [21:0] c);
        cyc_t e;
        e.run = in_run; e.pm = in_pm; e.pv = in_pv; e.status = in_status; e.zf = in_zf;
        e.op = in_op; e.state = s; e.ctl = c;
        exp_q.push_back(e);
    endtask

    // Replays up to n queued cycles (all when n == 0), then discards the rest.
    task automatic play(input string tag, input int n);
        cyc_t e;
        int   k;
        k = 0;
        while (exp_q.size() > 0 && (n == 0 || k < n)) begin
            e = exp_q.pop_front();
            run = e.run; prog_mode = e.pm; prog_valid = e.pv;
            status = e.status; zero_flag = e.zf; opcode = e.op;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, k), {state_dbg, observed()}, {e.state, e.ctl});
            check($sformatf("%s_inv[%0d]", tag, k),
                  {22'd0, apc & bc, mem_we & ~apc, pc_load & latch_pc_load,
                   prog_ready & prev_ready}, 26'd0);
            prev_ready = prog_ready;
            k++;
        end
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_async"}, {state_dbg, observed()}, {S_RESET, C_APS});
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {state_dbg, observed()}, {S_RESET, C_APS});
        reset_n    = 1'b1;
        prev_ready = 1'b0;
        in_run = 1'b0; in_pm = 1'b0; in_pv = 1'b0;
        push(S_RESET, C_APS | C_CLRS);
        push(S_IDLE, C_APS);
        push(S_IDLE, C_APS);
        play({tag, "_boot"}, 0);
    endtask

    // One instruction: fetch, decode, then the execute cycles of its (resolved) opcode.
    task automatic gen_instr(input logic [2:0] op, input logic zf, input logic st);
        logic [2:0] eff;
        in_run = 1'b1; in_pm = 1'b0; in_pv = 1'b0; in_op = op; in_zf = zf; in_status = st;
        push(S_FADDR, C_APS | C_MAR);
        for (int i = 0; i <= W; i++) push(S_FREAD, C_APS | C_BC | ((i == W) ? C_IRL : 22'd0));
        push(S_FINC, C_APS | C_STEP);
        push(S_DECODE, C_APS);
        if (!st) begin
            push(S_HALT, C_APS | C_HLT);
            return;
        end
        eff = (op == 3'd7) ? (zf ? 3'd3 : 3'd0) : op;
        case (eff)
            3'd1, 3'd2, 3'd5: push(S_E1, C_APS | C_IPS | C_MAR);
            3'd3:             push(S_E1, C_APS | C_ALU | C_LPC);
            3'd4:             push(S_E1, C_APS | C_BSRC | C_BL);
            3'd6:             push(S_E1, C_APS | C_ALU | C_AL);
            default:          push(S_E1, C_APS);
        endcase
        case (eff)
            3'd1: for (int i = 0; i <= W; i++)
                push(S_E2, C_APS | C_BC | ((i == W) ? C_BL : 22'd0));
            3'd2: begin
                for (int i = 0; i <= W; i++) push(S_E2, C_APS | C_APC | C_WE);
                push(S_E2, C_APS | C_APC);
            end
            3'd5: for (int i = 0; i <= W; i++)
                push(S_E2, C_APS | C_BC | ((i == W) ? C_SHOW : 22'd0));
            3'd3: push(S_E2, C_APS | C_PCL);
            default: ;
        endcase
    endtask

    task automatic gen_idle();
        in_run = 1'b0; in_pm = 1'b0;
        push(S_IDLE, C_APS);
    endtask

    task automatic gen_prog_byte(input int gap);
        in_pv = 1'($urandom_range(0, 1));
        push(S_PWAIT, C_APC);
        in_pv = 1'b0;
        for (int i = 0; i < gap; i++) push(S_PWAIT, C_APC);
        in_pv = 1'b1;
        push(S_PWAIT, C_APC | C_RDY);
        for (int i = 0; i <= W; i++) begin
            in_pv = 1'($urandom_range(0, 1));
            push(S_PWR, C_APC | C_WE);
        end
        in_pv = 1'b0;
        push(S_PINC, C_APS | C_STEP);
        push(S_PADDR, C_APS | C_MAR);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset("reset");

        // Programming mode: four bytes, then drop prog_mode back to RESET.
        in_pm = 1'b1; in_run = 1'b0; in_pv = 1'b0;
        push(S_PADDR, C_APS | C_MAR);
        for (int b = 0; b < 4; b++) gen_prog_byte(int'($urandom_range(0, 2)));
        in_pm = 1'b0;
        push(S_RESET, C_APS | C_CLRS);
        push(S_IDLE, C_APS);
        play("prog", 0);

        gen_instr(3'd1, 1'b0, 1'b1);
        gen_idle();
        play("load", 0);

        gen_instr(3'd7, 1'b0, 1'b1);
        gen_instr(3'd7, 1'b1, 1'b1);
        gen_idle();
        play("brz", 0);

        for (int n = 0; n < 16; n++) begin
            gen_instr(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1);
            if ($urandom_range(0, 3) == 0) gen_idle();
        end
        gen_idle();
        play("rand", 0);

        // Stop inside the first STORE write cycle and pull reset asynchronously.
        gen_instr(3'd2, 1'b0, 1'b1);
        play("store", W + 6);
        do_reset("store_abort");

        gen_instr(3'd0, 1'b0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            in_run = 1'($urandom_range(0, 1));
            in_pm  = 1'($urandom_range(0, 1));
            push(S_HALT, C_APS | C_HLT);
        end
        play("halt", 0);
        do_reset("halt_clear");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
